// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU between two
// requesters. Operands are registered onto the ALU. For a MUL, the operands
// are held for MUL_LAT cycles before the result is sampled. The result is
// held in a response register until the consumer accepts it.
//
// Handshake rule (all ports): a transfer happens on a rising clock edge
// where valid && ready are both high. Requesters may drop valid at any
// time before that edge. req*_ready is asserted only in IDLE, and only to
// the granted port. The response stays stable while rsp_valid && !rsp_ready.
//
// Optional build macro: ALU_SHARE_ARB_PERF_EN adds saturating grant and
// conflict counters (perf_grant0, perf_grant1, perf_conflict).
module alu_share_arb #(
    parameter int MUL_LAT = 2,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_opA,
    input  logic [W-1:0] req0_opB,
    input  logic [4:0]   req0_opcode,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_opA,
    input  logic [W-1:0] req1_opB,
    input  logic [4:0]   req1_opcode,
    output logic [W-1:0] alu_opA,
    output logic [W-1:0] alu_opB,
    output logic [4:0]   alu_opcode,
    input  logic [W-1:0] alu_out,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_zero,
    output logic [1:0]   dbg_state
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [15:0]  perf_grant0,
    output logic [15:0]  perf_grant1,
    output logic [15:0]  perf_conflict
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [4:0] MUL_OP  = 5'b01001;
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    state_t       state;
    logic         rr_ptr;
    logic         owner;
    logic [3:0]   cnt;

    logic         both_valid;
    logic         grant_id;
    logic         in_idle;
    logic         grant;
    logic [W-1:0] sel_opA;
    logic [W-1:0] sel_opB;
    logic [4:0]   sel_opcode;

    // Arbitration: a lone valid port wins; on contention rr_ptr decides.
    // Ready is masked during reset so every output reads 0 while rst is high.
    assign both_valid = req0_valid & req1_valid;
    assign grant_id   = both_valid ? rr_ptr : req1_valid;
    assign in_idle    = (state == IDLE) & ~rst;
    assign req0_ready = in_idle & req0_valid & ~grant_id;
    assign req1_ready = in_idle & req1_valid & grant_id;
    assign grant      = req0_ready | req1_ready;
    assign sel_opA    = grant_id ? req1_opA    : req0_opA;
    assign sel_opB    = grant_id ? req1_opB    : req0_opB;
    assign sel_opcode = grant_id ? req1_opcode : req0_opcode;
    assign dbg_state  = state;

    // Control FSM: grant in IDLE, settle in EXEC, hold the response in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            cnt        <= 4'd0;
            alu_opA    <= '0;
            alu_opB    <= '0;
            alu_opcode <= 5'd0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        alu_opA    <= sel_opA;
                        alu_opB    <= sel_opB;
                        alu_opcode <= sel_opcode;
                        owner      <= grant_id;
                        cnt        <= (sel_opcode == MUL_OP) ? MUL_CNT : 4'd0;
                        rr_ptr     <= ~grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_data  <= alu_out;
                        rsp_zero  <= alu_zero;
                        rsp_id    <= owner;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_ARB_PERF_EN
    // Saturating per-port grant counts and contended-IDLE-cycle count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_grant0   <= 16'd0;
            perf_grant1   <= 16'd0;
            perf_conflict <= 16'd0;
        end else begin
            if (req0_ready && perf_grant0 != 16'hFFFF) begin
                perf_grant0 <= perf_grant0 + 16'd1;
            end
            if (req1_ready && perf_grant1 != 16'hFFFF) begin
                perf_grant1 <= perf_grant1 + 16'd1;
            end
            if (in_idle && both_valid && perf_conflict != 16'hFFFF) begin
                perf_conflict <= perf_conflict + 16'd1;
            end
        end
    end
`endif

endmodule
